// File: rtl/multi_button_debouncer.sv
// Synchronises and debounces NUM_BUTTONS raw inputs, then applies a single-press
// lockout that emits press/release pulses and counts accepted presses.
module multi_button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int ID_W            = 1,
    parameter int PCNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_clean,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic                   locked,
    output logic [ID_W-1:0]        active_id,
    output logic [PCNT_W-1:0]      press_count
);

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] clean_q, clean_d;
    logic [NUM_BUTTONS-1:0] rise_q, fall_q;
    logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];

    state_t                 state_q;
    logic [NUM_BUTTONS-1:0] press_pulse_q, release_pulse_q;
    logic                   locked_q;
    logic [ID_W-1:0]        active_id_q;
    logic [PCNT_W-1:0]      press_count_q;

    logic                   any_rise;
    logic [ID_W-1:0]        sel_idx;
    logic                   active_fall;

    // Any return to the stable level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing samples flips the level.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
            fall_q  <= ~clean_d & clean_q;
            for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Descending scan leaves the lowest rising index as the winner.
    always_comb begin
        any_rise    = |rise_q;
        sel_idx     = '0;
        active_fall = 1'b0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (rise_q[i]) sel_idx = ID_W'(i);
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (fall_q[i] && (active_id_q == ID_W'(i))) active_fall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            locked_q        <= 1'b0;
            active_id_q     <= '0;
            press_count_q   <= '0;
        end else begin
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_rise) begin
                        press_pulse_q <= NUM_BUTTONS'(1) << sel_idx;
                        active_id_q   <= sel_idx;
                        locked_q      <= 1'b1;
                        press_count_q <= press_count_q + PCNT_W'(1);
                        state_q       <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (active_fall) begin
                        release_pulse_q <= NUM_BUTTONS'(1) << active_id_q;
                        locked_q        <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btn_clean     = clean_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign locked        = locked_q;
    assign active_id     = active_id_q;
    assign press_count   = press_count_q;

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- Receive-side counterpart to the multi-button bounce emulator.
- Synchronises NUM_BUTTONS raw, bouncing mechanical inputs and debounces each one independently.
- Applies a single-press lockout: only one button may be "active" at a time.
- Emits clean levels, one-cycle press/release pulses and a wrapping accepted-press counter for downstream FSMs.

Parameters:
- NUM_BUTTONS, 2, number of raw button inputs (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change (>=2).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ID_W, 1, width of active_id; must satisfy 2^ID_W >= NUM_BUTTONS.
- PCNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed.
- btn_clean  output  NUM_BUTTONS  debounced level per button.
- press_pulse  output  NUM_BUTTONS  one-cycle pulse when a press is accepted under lockout.
- release_pulse  output  NUM_BUTTONS  one-cycle pulse when the active button's debounced level falls.
- locked  output  1  high while a press is held and other presses are blocked.
- active_id  output  ID_W  index of the accepted button; holds its last value when unlocked.
- press_count  output  PCNT_W  count of accepted presses, wraps modulo 2^PCNT_W.

Behaviour:
- Reset (rst_n low, async): all outputs 0, both synchroniser stages 0, all debounce counters 0, FSM = IDLE.
- Synchroniser: two flops per bit; s2[i] is btn_raw[i] delayed 2 edges.
- Per-button debounce:
  - If s2[i] == btn_clean[i], cnt[i] <= 0. A bounce back to the stable level mid-count restarts the count.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, btn_clean[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i] + 1.
  - Latency: a clean step on btn_raw appears on btn_clean DEBOUNCE_CYCLES+2 edges later.
- Events, registered internally:
  - rise[i] = btn_clean[i] goes 0->1.
  - fall[i] = btn_clean[i] goes 1->0.
- Lockout FSM, states IDLE and LOCKED:
  - IDLE: if any rise[i], select the lowest index i with rise set. On the same edge: press_pulse[i] <= 1, active_id <= i, locked <= 1, press_count <= press_count+1, state -> LOCKED. Rises on other buttons in that cycle are discarded.
  - LOCKED: rise on any other button is ignored (no pulse, no count). When fall[active_id] occurs: release_pulse[active_id] <= 1, locked <= 0, state -> IDLE.
  - Falls of non-active buttons produce no pulse in either state.
- Pulses are exactly one cycle wide and at most one bit of press_pulse/release_pulse is set per cycle.
- Pulse timing: press_pulse/release_pulse assert on the edge after the btn_clean transition that caused them.
- Simultaneous events: another button's rise in the same cycle as the release is discarded. A button still held when the FSM returns to IDLE is not accepted until it is released and pressed again.
- press_count wraps from 2^PCNT_W-1 to 0 with no flag.
- Reset mid-press: everything clears immediately. A button held through reset is debounced to 1 again after DEBOUNCE_CYCLES+2 edges and is then accepted as a new press.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, NUM_BUTTONS=2.
- Clean press: btn_raw=01 stepped at edge 0 and held -> btn_clean[0]=1 after edge 6; press_pulse=01 for one cycle; locked=1; active_id=0; press_count=1.
- Bounce rejection: btn_raw[0] toggles 1,0,1,0 each cycle, then holds 1 -> btn_clean stays 0 until 4 stable synchronised cycles; exactly one press_pulse.
- Lockout: press button 0, then button 1 while 0 is held -> btn_clean=11, no press_pulse[1], press_count stays 1. Release 0 -> release_pulse=01, locked=0. Button 1 still held -> no press accepted.
- Simultaneous press: btn_raw 00->11 on the same edge -> press_pulse=01 only, active_id=0.
- Wrap and reset: with PCNT_W=2, 5 accepted press/release cycles -> press_count=1. Then assert rst_n low while a button is held -> all outputs 0 asynchronously; after deassertion, re-press is accepted after 6 edges.
